// File: rtl/sweep_result_buffer.sv
// -----------------------------------------------------------------------------
// sweep_result_buffer
//
// Purpose:
//   Captures MODULO/PHASE measurements strobed by the control path, averages
//   2^AVG_LOG2 consecutive measurements per sweep point and stores one
//   averaged pair per point in an internal RAM indexed by point number.
//   A latency-1 synchronous read port serves host/readout logic, and a
//   single-cycle sweep_done pulse marks completion of a full sweep.
//
// Optional feature macro: SWEEP_PEAK_EN
//   When defined, peak_modulo/peak_idx track the largest averaged magnitude
//   written during the current sweep (first index wins on ties).
//
// Ports:
//   clk125       in   sole clock, rising edge
//   areset_n     in   asynchronous active-low reset
//   start        in   single-cycle pulse, begins or restarts a sweep
//   meas_valid   in   single-cycle strobe, modulo/phase valid this cycle
//   modulo       in   measured magnitude (unsigned)
//   phase        in   measured phase (signed two's complement)
//   rd_en        in   read request
//   rd_addr      in   point index to read
//   rd_modulo    out  averaged magnitude read back
//   rd_phase     out  averaged phase read back
//   rd_valid     out  read data valid
//   busy         out  high while a sweep is accumulating
//   point_idx    out  index of the point currently being accumulated
//   sweep_done   out  single-cycle pulse at end of sweep
//   peak_modulo  out  (SWEEP_PEAK_EN) largest averaged magnitude this sweep
//   peak_idx     out  (SWEEP_PEAK_EN) point index of peak_modulo
//   fsm_state    out  debug view of the control FSM (0=IDLE 1=ACCUM 2=DONE)
//
// Handshake semantics: there is no backpressure anywhere. meas_valid and
// start are valid-only strobes consumed in the cycle they are high. rd_en is
// a valid-only request; rd_valid is asserted exactly one cycle after each
// rd_en and the read data registers hold their value when rd_en is low.
// -----------------------------------------------------------------------------
module sweep_result_buffer #(
  parameter int ADDR_WIDTH     = 8,
  parameter int MAGNITUD_WIDTH = 14,
  parameter int PHASE_WIDTH    = 14,
  parameter int AVG_LOG2       = 2
) (
  input  logic                      clk125,
  input  logic                      areset_n,
  input  logic                      start,
  input  logic                      meas_valid,
  input  logic [MAGNITUD_WIDTH-1:0] modulo,
  input  logic [PHASE_WIDTH-1:0]    phase,
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [MAGNITUD_WIDTH-1:0] rd_modulo,
  output logic [PHASE_WIDTH-1:0]    rd_phase,
  output logic                      rd_valid,
  output logic                      busy,
  output logic [ADDR_WIDTH-1:0]     point_idx,
  output logic                      sweep_done,
`ifdef SWEEP_PEAK_EN
  output logic [MAGNITUD_WIDTH-1:0] peak_modulo,
  output logic [ADDR_WIDTH-1:0]     peak_idx,
`endif
  output logic [1:0]                fsm_state
);

  localparam int NUM_POINTS = 1 << ADDR_WIDTH;
  localparam int MACC_W     = MAGNITUD_WIDTH + AVG_LOG2;
  localparam int PACC_W     = PHASE_WIDTH + AVG_LOG2;
  // Counter is kept at least one bit wide so AVG_LOG2=0 still elaborates;
  // in that case every accepted sample is the completing one.
  localparam int CNT_W      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_POINT = ADDR_WIDTH'(NUM_POINTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]         sample_cnt;
  logic [MACC_W-1:0]        mod_acc;
  logic signed [PACC_W-1:0] ph_acc;

  logic                     accept;
  logic                     last_sample;
  logic                     last_point;
  logic                     complete;
  logic [MACC_W-1:0]        mod_sum;
  logic signed [PACC_W-1:0] ph_ext;
  logic signed [PACC_W-1:0] ph_sum;
  logic [MAGNITUD_WIDTH-1:0] mod_avg;
  logic [PHASE_WIDTH-1:0]    ph_avg;

  logic [MAGNITUD_WIDTH+PHASE_WIDTH-1:0] mem [NUM_POINTS];

  // A start in the same cycle as a strobe aborts the sweep, so the strobe
  // is never accepted.
  assign accept      = (state == ST_ACCUM) && meas_valid && !start;
  assign last_sample = (sample_cnt == CNT_LAST);
  assign last_point  = (point_idx == LAST_POINT);
  assign complete    = accept && last_sample;

  // Sums include the current sample so the completing strobe writes the
  // average on its own edge without an extra pipeline stage.
  assign mod_sum = mod_acc + MACC_W'(modulo);
  assign ph_ext  = PACC_W'($signed(phase));
  assign ph_sum  = ph_acc + ph_ext;
  assign mod_avg = MAGNITUD_WIDTH'(mod_sum >> AVG_LOG2);
  assign ph_avg  = PHASE_WIDTH'(ph_sum >>> AVG_LOG2);

  // State register
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (!start && complete && last_point) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state == ST_ACCUM);
    fsm_state = state;
  end

  // Accumulation datapath
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      sample_cnt <= '0;
      mod_acc    <= '0;
      ph_acc     <= '0;
      point_idx  <= '0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (start) begin
        sample_cnt <= '0;
        mod_acc    <= '0;
        ph_acc     <= '0;
        point_idx  <= '0;
      end else if (accept) begin
        if (last_sample) begin
          sample_cnt <= '0;
          mod_acc    <= '0;
          ph_acc     <= '0;
          // Natural wrap returns point_idx to 0 after the last point.
          point_idx  <= point_idx + 1'b1;
          if (last_point) sweep_done <= 1'b1;
        end else begin
          sample_cnt <= sample_cnt + 1'b1;
          mod_acc    <= mod_sum;
          ph_acc     <= ph_sum;
        end
      end
    end
  end

`ifdef SWEEP_PEAK_EN
  // Strict compare keeps the first index on ties.
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      peak_modulo <= '0;
      peak_idx    <= '0;
    end else if (start) begin
      peak_modulo <= '0;
      peak_idx    <= '0;
    end else if (complete && (mod_avg > peak_modulo)) begin
      peak_modulo <= mod_avg;
      peak_idx    <= point_idx;
    end
  end
`endif

  // Result RAM: not reset, so points survive a reset.
  always_ff @(posedge clk125) begin
    if (complete) mem[point_idx] <= {mod_avg, ph_avg};
  end

  // Read port; a same-address write in the same cycle returns the old word.
  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      rd_modulo <= '0;
      rd_phase  <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) {rd_modulo, rd_phase} <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_sweep_result_buffer.sv
module tb_sweep_result_buffer;

  localparam int AW    = 2;
  localparam int MW    = 14;
  localparam int PW    = 14;
  localparam int AL    = 2;
  localparam int NP    = 1 << AW;
  localparam int NSAMP = 1 << AL;

  // ---------------- clock / reset ----------------
  logic clk125 = 1'b0;
  logic areset_n = 1'b0;
  always #4 clk125 = ~clk125;

  logic          start = 1'b0;
  logic          meas_valid = 1'b0;
  logic [MW-1:0] modulo = '0;
  logic [PW-1:0] phase = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [MW-1:0] rd_modulo;
  logic [PW-1:0] rd_phase;
  logic          rd_valid;
  logic          busy;
  logic [AW-1:0] point_idx;
  logic          sweep_done;
  logic [1:0]    fsm_state;
`ifdef SWEEP_PEAK_EN
  logic [MW-1:0] peak_modulo;
  logic [AW-1:0] peak_idx;
`endif

  sweep_result_buffer #(
    .ADDR_WIDTH(AW), .MAGNITUD_WIDTH(MW), .PHASE_WIDTH(PW), .AVG_LOG2(AL)
  ) dut (
    .clk125(clk125), .areset_n(areset_n), .start(start),
    .meas_valid(meas_valid), .modulo(modulo), .phase(phase),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_modulo(rd_modulo),
    .rd_phase(rd_phase), .rd_valid(rd_valid), .busy(busy),
    .point_idx(point_idx), .sweep_done(sweep_done),
`ifdef SWEEP_PEAK_EN
    .peak_modulo(peak_modulo), .peak_idx(peak_idx),
`endif
    .fsm_state(fsm_state)
  );

  // ---------------- reference model ----------------
  int total = 0;
  int bad = 0;
  int exp_mod[NP];
  int exp_ph[NP];
  bit known[NP];
  int m_q[$];
  int p_q[$];
  bit m_active = 1'b0;
  int m_point = 0;
  int done_cnt = 0;

  // Average with rounding toward minus infinity.
  function automatic int floor_avg(input int s);
    if (s >= 0) return s / NSAMP;
    return -((-s + NSAMP - 1) / NSAMP);
  endfunction

  task automatic model_strobe(input int m, input int p, output bit done);
    int sm, sp;
    done = 1'b0;
    if (!m_active) return;
    m_q.push_back(m);
    p_q.push_back(p);
    if (m_q.size() == NSAMP) begin
      sm = 0; sp = 0;
      foreach (m_q[i]) sm += m_q[i];
      foreach (p_q[i]) sp += p_q[i];
      exp_mod[m_point] = floor_avg(sm);
      exp_ph[m_point]  = floor_avg(sp);
      known[m_point]   = 1'b1;
      m_q.delete();
      p_q.delete();
      m_point++;
      if (m_point == NP) begin
        m_point  = 0;
        m_active = 1'b0;
        done     = 1'b1;
      end
    end
  endtask

  task automatic model_start();
    m_active = 1'b1;
    m_point  = 0;
    m_q.delete();
    p_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk125);
    #1;
  endtask

  task automatic do_start(input bit with_mv);
    start      = 1'b1;
    meas_valid = with_mv;
    modulo     = MW'($urandom_range(16383));
    phase      = PW'($urandom_range(16383));
    cycle();
    start      = 1'b0;
    meas_valid = 1'b0;
    model_start();
  endtask

  task automatic send_meas(input int m, input int p, input bit do_rd,
                           input int addr, output bit done);
    modulo     = MW'(m);
    phase      = PW'(p);
    meas_valid = 1'b1;
    rd_en      = do_rd;
    rd_addr    = AW'(addr);
    cycle();
    meas_valid = 1'b0;
    rd_en      = 1'b0;
    model_strobe(m, p, done);
  endtask

  task automatic do_read(input int addr);
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    cycle();
    rd_en   = 1'b0;
  endtask

  function automatic int rand_phase();
    return int'($urandom_range(16383)) - 8192;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    total += 6;
    if (rd_modulo !== '0) begin bad++; $display("FAIL reset_rd_modulo: got %0d expected 0", rd_modulo); end
    if (rd_phase !== '0) begin bad++; $display("FAIL reset_rd_phase: got %0d expected 0", rd_phase); end
    if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (point_idx !== '0) begin bad++; $display("FAIL reset_point_idx: got %0d expected 0", point_idx); end
    if (sweep_done !== 1'b0) begin bad++; $display("FAIL reset_sweep_done: got %b expected 0", sweep_done); end
    repeat (3) cycle();
    areset_n = 1'b1;
    cycle();
  endtask

  // Feeds one strobe and checks the status outputs against the model.
  task automatic test_strobe(input int m, input int p);
    bit done;
    send_meas(m, p, 1'b0, 0, done);
    if (sweep_done === 1'b1) done_cnt++;
    total += 3;
    if (sweep_done !== done) begin bad++; $display("FAIL sweep_done: got %b expected %b", sweep_done, done); end
    if (busy !== m_active) begin bad++; $display("FAIL busy: got %b expected %b", busy, m_active); end
    if (point_idx !== AW'(m_point)) begin bad++; $display("FAIL point_idx: got %0d expected %0d", point_idx, m_point); end
  endtask

  task automatic test_read_all();
    for (int a = 0; a < NP; a++) begin
      do_read(a);
      total += 3;
      if (rd_valid !== 1'b1) begin bad++; $display("FAIL rd_valid[%0d]: got %b expected 1", a, rd_valid); end
      if (rd_modulo !== MW'(exp_mod[a])) begin bad++; $display("FAIL rd_modulo[%0d]: got %0d expected %0d", a, rd_modulo, exp_mod[a]); end
      if (rd_phase !== PW'(exp_ph[a])) begin bad++; $display("FAIL rd_phase[%0d]: got %0d expected %0d", a, $signed(rd_phase), exp_ph[a]); end
      cycle();
      total += 2;
      if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_low[%0d]: got %b expected 0", a, rd_valid); end
      if (rd_modulo !== MW'(exp_mod[a])) begin bad++; $display("FAIL rd_hold[%0d]: got %0d expected %0d", a, rd_modulo, exp_mod[a]); end
    end
  endtask

  task automatic test_basic_sweep();
    do_start(1'b0);
    total += 2;
    if (busy !== 1'b1) begin bad++; $display("FAIL start_busy: got %b expected 1", busy); end
    if (point_idx !== '0) begin bad++; $display("FAIL start_point: got %0d expected 0", point_idx); end
    for (int pt = 0; pt < NP; pt++)
      for (int s = 0; s < NSAMP; s++) test_strobe(100 + pt, -8);
    cycle();
    total += 2;
    if (sweep_done !== 1'b0) begin bad++; $display("FAIL done_single_cycle: got %b expected 0", sweep_done); end
    if (busy !== 1'b0) begin bad++; $display("FAIL done_busy: got %b expected 0", busy); end
    // Strobes in DONE must not disturb anything.
    test_strobe(7, 7);
    test_read_all();
  endtask

  task automatic test_rounding();
    int pm[4] = '{1, 2, 2, 2};
    int pp[4] = '{-1, 0, 0, 0};
    do_start(1'b0);
    for (int s = 0; s < NSAMP; s++) test_strobe(pm[s], pp[s]);
    for (int s = NSAMP; s < NP * NSAMP; s++) test_strobe(int'($urandom_range(16383)), rand_phase());
    do_read(0);
    total += 2;
    if (rd_modulo !== MW'(1)) begin bad++; $display("FAIL round_modulo: got %0d expected 1", rd_modulo); end
    if (rd_phase !== PW'(-1)) begin bad++; $display("FAIL round_phase: got %0d expected -1", $signed(rd_phase)); end
    test_read_all();
  endtask

  task automatic test_max();
    do_start(1'b0);
    for (int s = 0; s < NP * NSAMP; s++) test_strobe(16383, -8192);
    test_read_all();
  endtask

  task automatic test_restart();
    done_cnt = 0;
    do_start(1'b0);
    for (int s = 0; s < 6; s++) test_strobe(int'($urandom_range(16383)), rand_phase());
    do_start(1'b1);
    total += 2;
    if (point_idx !== '0) begin bad++; $display("FAIL restart_point: got %0d expected 0", point_idx); end
    if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy: got %b expected 1", busy); end
    for (int s = 0; s < NP * NSAMP; s++) test_strobe(int'($urandom_range(16383)), rand_phase());
    total += 1;
    if (done_cnt !== 1) begin bad++; $display("FAIL restart_done_count: got %0d expected 1", done_cnt); end
    test_read_all();
  endtask

  task automatic test_async_reset();
    do_start(1'b0);
    for (int s = 0; s < 9; s++) test_strobe(int'($urandom_range(16383)), rand_phase());
    #2;
    areset_n = 1'b0;
    m_active = 1'b0;
    m_point  = 0;
    m_q.delete();
    p_q.delete();
    #1;
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy: got %b expected 0", busy); end
    if (point_idx !== '0) begin bad++; $display("FAIL areset_point: got %0d expected 0", point_idx); end
    if (sweep_done !== 1'b0) begin bad++; $display("FAIL areset_done: got %b expected 0", sweep_done); end
    cycle();
    areset_n = 1'b1;
    cycle();
    for (int s = 0; s < 5; s++) test_strobe(int'($urandom_range(16383)), rand_phase());
    for (int a = 0; a < 2; a++) begin
      do_read(a);
      total += 2;
      if (rd_modulo !== MW'(exp_mod[a])) begin bad++; $display("FAIL keep_modulo[%0d]: got %0d expected %0d", a, rd_modulo, exp_mod[a]); end
      if (rd_phase !== PW'(exp_ph[a])) begin bad++; $display("FAIL keep_phase[%0d]: got %0d expected %0d", a, $signed(rd_phase), exp_ph[a]); end
    end
  endtask

  // Random sweeps with gaps and reads aimed at the point being written,
  // so completing strobes also exercise read/write collisions.
  task automatic test_random();
    bit done;
    int old_m, old_p, addr;
    bit old_k, do_rd;
    for (int sw = 0; sw < 3; sw++) begin
      do_start(1'b0);
      while (m_active) begin
        repeat ($urandom_range(2)) begin
          cycle();
          total += 1;
          if (sweep_done !== 1'b0) begin bad++; $display("FAIL gap_done: got %b expected 0", sweep_done); end
        end
        do_rd = ($urandom_range(1) == 1);
        addr  = m_point;
        old_k = known[addr];
        old_m = exp_mod[addr];
        old_p = exp_ph[addr];
        send_meas(int'($urandom_range(16383)), rand_phase(), do_rd, addr, done);
        total += 3;
        if (sweep_done !== done) begin bad++; $display("FAIL rnd_done: got %b expected %b", sweep_done, done); end
        if (point_idx !== AW'(m_point)) begin bad++; $display("FAIL rnd_point: got %0d expected %0d", point_idx, m_point); end
        if (rd_valid !== do_rd) begin bad++; $display("FAIL rnd_rd_valid: got %b expected %b", rd_valid, do_rd); end
        if (do_rd && old_k) begin
          total += 2;
          if (rd_modulo !== MW'(old_m)) begin bad++; $display("FAIL coll_modulo[%0d]: got %0d expected %0d", addr, rd_modulo, old_m); end
          if (rd_phase !== PW'(old_p)) begin bad++; $display("FAIL coll_phase[%0d]: got %0d expected %0d", addr, $signed(rd_phase), old_p); end
        end
      end
      test_read_all();
    end
  endtask

`ifdef SWEEP_PEAK_EN
  task automatic test_peak();
    int avg[4] = '{50, 900, 900, 10};
    do_start(1'b0);
    total += 2;
    if (peak_modulo !== '0) begin bad++; $display("FAIL peak_clear: got %0d expected 0", peak_modulo); end
    if (peak_idx !== '0) begin bad++; $display("FAIL peak_idx_clear: got %0d expected 0", peak_idx); end
    for (int pt = 0; pt < NP; pt++)
      for (int s = 0; s < NSAMP; s++) test_strobe(avg[pt], 0);
    total += 2;
    if (peak_modulo !== MW'(900)) begin bad++; $display("FAIL peak_modulo: got %0d expected 900", peak_modulo); end
    if (peak_idx !== AW'(1)) begin bad++; $display("FAIL peak_idx: got %0d expected 1", peak_idx); end
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic_sweep();
    test_rounding();
    test_max();
    test_restart();
    test_async_reset();
    test_random();
`ifdef SWEEP_PEAK_EN
    test_peak();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
